axi_arp_tx: RTL and testbench

// - Downstream of the ARP FSM: accepts one ARP transmit request over the req/ack handshake.
// - Serialises it as an Ethernet II ARP frame on an 8-bit AXI-Stream master toward the MAC TX mux.
// - One frame in flight; fields are latched at acceptance, so the requester may change them after ack.

---
 rtl/axi_arp_tx.sv | 130 +++++++++++++
 tb/tb_axi_arp_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_arp_tx.sv
// Serialises one latched ARP request into an Ethernet II frame on an 8-bit AXI-Stream master.
// Define AXI_ARP_TX_PAD_EN to zero-pad the frame to the 60-byte Ethernet minimum.
module axi_arp_tx #(
  parameter int unsigned DEBUG      = 1,
  parameter int unsigned IFG_CYCLES = 0
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        arp_tx_req,
  output logic        arp_tx_ack,
  input  logic [15:0] arp_tx_opcode,
  input  logic [47:0] arp_tx_src_mac,
  input  logic [31:0] arp_tx_src_ip,
  input  logic [47:0] arp_tx_dst_mac,
  input  logic [31:0] arp_tx_dst_ip,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy
);

`ifdef AXI_ARP_TX_PAD_EN
  localparam logic [5:0] LastIdx = 6'd59;
`else
  localparam logic [5:0] LastIdx = 6'd41;
`endif
  localparam logic [5:0] HdrLast = 6'd41;
  localparam logic [7:0] IfgLast = 8'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StAck, StFrame, StIfg} state_e;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  ifg_q, ifg_d;
  logic [15:0] opcode_q;
  logic [47:0] src_mac_q, dst_mac_q;
  logic [31:0] src_ip_q, dst_ip_q;

  logic          load;
  logic          beat;
  logic [47:0]   tha;
  logic [335:0]  hdr;

  assign load = (state_q == StIdle) && arp_tx_req;
  assign beat = (state_q == StFrame) && m_axis_tready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ifg_d   = ifg_q;
    unique case (state_q)
      StIdle: begin
        if (arp_tx_req) state_d = StAck;
      end
      StAck: begin
        state_d = StFrame;
        idx_d   = 6'd0;
      end
      StFrame: begin
        if (beat) begin
          if (idx_q == LastIdx) begin
            idx_d   = 6'd0;
            ifg_d   = 8'd0;
            state_d = (IFG_CYCLES > 0) ? StIfg : StIdle;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      StIfg: begin
        if (ifg_q == IfgLast) state_d = StIdle;
        else                  ifg_d   = ifg_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      idx_q     <= 6'd0;
      ifg_q     <= 8'd0;
      opcode_q  <= 16'd0;
      src_mac_q <= 48'd0;
      src_ip_q  <= 32'd0;
      dst_mac_q <= 48'd0;
      dst_ip_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ifg_q   <= ifg_d;
      if (load) begin
        opcode_q  <= arp_tx_opcode;
        src_mac_q <= arp_tx_src_mac;
        src_ip_q  <= arp_tx_src_ip;
        dst_mac_q <= arp_tx_dst_mac;
        dst_ip_q  <= arp_tx_dst_ip;
      end
    end
  end

  // Only a request (oper 1) carries an unknown target hardware address.
  assign tha = (opcode_q == 16'd1) ? 48'h0 : dst_mac_q;
  assign hdr = {dst_mac_q, src_mac_q, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                opcode_q, src_mac_q, src_ip_q, tha, dst_ip_q};

  // Byte 0 sits in the top of hdr; indices past the header are zero pad.
  always_comb begin
    m_axis_tdata = 8'h00;
    if ((state_q == StFrame) && (idx_q <= HdrLast)) begin
      m_axis_tdata = hdr[{HdrLast - idx_q, 3'b000} +: 8];
    end
  end

  assign m_axis_tvalid = (state_q == StFrame);
  assign m_axis_tlast  = (state_q == StFrame) && (idx_q == LastIdx);
  assign arp_tx_ack    = (state_q == StAck);
  assign busy          = (state_q != StIdle);

  if (DEBUG != 0) begin : g_debug
    always_ff @(posedge clk) begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        $display("%0t axi_arp_tx: op=%04h dst_mac=%012h dst_ip=%08h",
                 $time, opcode_q, dst_mac_q, dst_ip_q);
      end
    end
  end

endmodule

// File: tb/tb_axi_arp_tx.sv
// Scoreboard bench for axi_arp_tx: expected beats are queued at request time and a monitor
// compares every presented beat against the queue head.
module tb_axi_arp_tx;

`ifdef AXI_ARP_TX_PAD_EN
  localparam int L = 59;
`else
  localparam int L = 41;
`endif

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        arp_tx_req = 1'b0;
  logic        arp_tx_ack;
  logic [15:0] arp_tx_opcode = '0;
  logic [47:0] arp_tx_src_mac = '0;
  logic [31:0] arp_tx_src_ip = '0;
  logic [47:0] arp_tx_dst_mac = '0;
  logic [31:0] arp_tx_dst_ip = '0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        busy;

  axi_arp_tx #(
    .DEBUG      (0),
    .IFG_CYCLES (3)
  ) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .arp_tx_req     (arp_tx_req),
    .arp_tx_ack     (arp_tx_ack),
    .arp_tx_opcode  (arp_tx_opcode),
    .arp_tx_src_mac (arp_tx_src_mac),
    .arp_tx_src_ip  (arp_tx_src_ip),
    .arp_tx_dst_mac (arp_tx_dst_mac),
    .arp_tx_dst_ip  (arp_tx_dst_ip),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .busy           (busy)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  cap[64];
  int          cur_idx = 0;
  int          last_len = 0;
  int          total_beats = 0;
  int          ack_count = 0;
  int          req_count = 0;
  int          tlast_cyc = 0;
  int          ack_cyc = 0;
  bit          bp = 1'b0;
  logic [3:0]  bp_pat = 4'b1001;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected frame built field by field from the frame layout.
  task automatic push_frame(input logic [15:0] op, input logic [47:0] sm, input logic [31:0] si,
                            input logic [47:0] dm, input logic [31:0] di);
    logic [7:0]  b[$];
    logic [47:0] tha;
    logic [15:0] fixed[3];
    fixed[0] = 16'h0806;
    fixed[1] = 16'h0001;
    fixed[2] = 16'h0800;
    tha = (op == 16'd1) ? 48'h0 : dm;
    for (int i = 5; i >= 0; i--) b.push_back(dm[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(sm[i*8 +: 8]);
    for (int k = 0; k < 3; k++) begin
      b.push_back(fixed[k][15:8]);
      b.push_back(fixed[k][7:0]);
    end
    b.push_back(8'h06);
    b.push_back(8'h04);
    b.push_back(op[15:8]);
    b.push_back(op[7:0]);
    for (int i = 5; i >= 0; i--) b.push_back(sm[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) b.push_back(si[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(tha[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) b.push_back(di[i*8 +: 8]);
    while (b.size() < L + 1) b.push_back(8'h00);
    for (int k = 0; k <= L; k++) exp_q.push_back({(k == L), b[k]});
  endtask

  task automatic start_req(input logic [15:0] op, input logic [47:0] sm, input logic [31:0] si,
                           input logic [47:0] dm, input logic [31:0] di);
    push_frame(op, sm, si, dm, di);
    arp_tx_opcode  = op;
    arp_tx_src_mac = sm;
    arp_tx_src_ip  = si;
    arp_tx_dst_mac = dm;
    arp_tx_dst_ip  = di;
    arp_tx_req     = 1'b1;
    req_count++;
  endtask

  // exp_lat counts negedges from raising req until ack is seen; 0 skips that check.
  task automatic wait_ack(input int exp_lat);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (arp_tx_ack) got = 1'b1;
    end
    check("ack_seen", got, 1'b1);
    if (exp_lat != 0) check("ack_latency", n, exp_lat);
    ack_cyc = cyc;
    @(posedge clk);
    #1;
    arp_tx_req = 1'b0;
    arp_tx_opcode = 16'hdead;
    arp_tx_dst_mac = 48'h0;
    @(negedge clk);
    check("ack_one_cycle", arp_tx_ack, 1'b0);
    check("first_tvalid", m_axis_tvalid, 1'b1);
    check("busy_in_frame", busy, 1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (8) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (bp) m_axis_tready = bp_pat[cyc % 4];
    else    m_axis_tready = 1'b1;
  end

  // Monitor: compare each presented beat with the queue head, pop on handshake.
  initial forever begin
    @(negedge clk or negedge aresetn);
    if (!aresetn) begin
      cur_idx = 0;
    end else begin
      if (arp_tx_ack) ack_count++;
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {m_axis_tlast, m_axis_tdata}, 9'h1ff);
        end else begin
          check("beat", {m_axis_tlast, m_axis_tdata}, exp_q[0]);
          if (m_axis_tready) begin
            void'(exp_q.pop_front());
            if (cur_idx < 64) cap[cur_idx] = m_axis_tdata;
            total_beats++;
            if (m_axis_tlast) begin
              last_len  = cur_idx + 1;
              tlast_cyc = cyc;
              cur_idx   = 0;
            end else begin
              cur_idx++;
            end
          end
        end
      end
    end
  end

  initial begin
    int base;
    int n;
    #2;
    check("rst_ack", arp_tx_ack, 1'b0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tdata", m_axis_tdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #2;
    aresetn = 1'b1;
    @(posedge clk);
    #1;

    // Reply request
    start_req(16'd2, 48'h010203040506, 32'hc0a80602, 48'ha1a2a3a4a5a6, 32'hc0a80601);
    wait_ack(2);
    wait_drain();
    check("reply_len", last_len, L + 1);
    check("reply_b12", cap[12], 8'h08);
    check("reply_b13", cap[13], 8'h06);
    check("reply_b20", cap[20], 8'h00);
    check("reply_b21", cap[21], 8'h02);
    check("reply_b32", cap[32], 8'ha1);
    check("reply_b37", cap[37], 8'ha6);
    check("reply_b41", cap[41], 8'h01);

    // Lookup request
    @(posedge clk);
    #1;
    start_req(16'd1, 48'h010203040506, 32'hc0a80602, 48'hffffffffffff, 32'hc0a80663);
    wait_ack(2);
    wait_drain();
    check("lookup_b0", cap[0], 8'hff);
    check("lookup_b5", cap[5], 8'hff);
    check("lookup_b32", cap[32], 8'h00);
    check("lookup_b37", cap[37], 8'h00);
    check("lookup_b38", cap[38], 8'hc0);
    check("lookup_b41", cap[41], 8'h63);

    // Backpressure
    bp = 1'b1;
    @(posedge clk);
    #1;
    base = total_beats;
    start_req(16'd2, 48'h010203040506, 32'hc0a80602, 48'ha1a2a3a4a5a6, 32'hc0a80601);
    wait_ack(2);
    wait_drain();
    check("bp_len", last_len, L + 1);
    check("bp_handshakes", total_beats - base, L + 1);
    bp = 1'b0;

    // Back-to-back with req held across the first frame; odd opcode sent verbatim
    @(posedge clk);
    #1;
    start_req(16'd2, 48'h0a0b0c0d0e0f, 32'h0a000001, 48'h112233445566, 32'h0a000002);
    wait_ack(2);
    start_req(16'd3, 48'h0a0b0c0d0e0f, 32'h0a000001, 48'h778899aabbcc, 32'h0a000003);
    wait_ack(0);
    check("ifg_gap", ack_cyc - tlast_cyc, 5);
    wait_drain();
    check("b2b_b32", cap[32], 8'h77);
    check("ack_count_b2b", ack_count, req_count);

    // Mid-frame reset
    @(posedge clk);
    #1;
    base = total_beats;
    start_req(16'd2, 48'h010203040506, 32'hc0a80602, 48'ha1a2a3a4a5a6, 32'hc0a80601);
    wait_ack(2);
    n = 0;
    while (total_beats - base < 20 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reach_beat20", total_beats - base, 20);
    #1;
    aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    check("mid_rst_tlast", m_axis_tlast, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    exp_q.delete();
    start_req(16'd1, 48'h010203040506, 32'hc0a80602, 48'hffffffffffff, 32'hc0a80605);
    #1;
    aresetn = 1'b1;
    wait_ack(2);
    wait_drain();
    check("post_rst_len", last_len, L + 1);
    check("post_rst_b41", cap[41], 8'h05);
    check("ack_count_final", ack_count, req_count);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
